// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_WR_WAIT = 1'b1
    } arb_state_e;

    localparam logic ARB_M_CPU    = 1'b0;
    localparam logic ARB_M_LOADER = 1'b1;

    // Same encodings as the MEM_ACCESS_* defines in const.v, mirrored here
    // so that SystemVerilog users of the arbiter can name access sizes.
    localparam logic [1:0] MEM_ACCESS_BYTE = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALF = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick. On a conflict the master that was not granted
// last wins; otherwise the sole requester is picked. Holds no state.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       pick_o
);

    // Winner selection from the request pair and the previous winner.
    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            pick_o = ~last_i;
        end else begin
            pick_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU load/store path (master 0) and the USB loader/debug
// master (master 1) onto the single mem_control data port.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ARB_IDLE    | arbitrate; reads and ready writes complete in one cycle
// ARB_WR_WAIT | port locked to owner_q until wr_ready or write timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WR_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_acc_i,
    input  logic        m0_sext_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_err_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_acc_i,
    input  logic        m1_sext_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_err_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        mem_r_en_o,
    output logic        mem_sext_o,
    output logic [1:0]  mem_acc_r_o,
    output logic [31:0] mem_addr_r_o,

    output logic        mem_wr_en_o,
    output logic [1:0]  mem_acc_w_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o,

    input  logic [31:0] mem_data_r_i,
    input  logic        mem_wr_ready_i
);

    // A zero timeout still needs a one-bit counter to keep the RTL legal.
    localparam int              CNT_W   = (WR_TIMEOUT > 0) ? $clog2(WR_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = (WR_TIMEOUT > 0) ? CNT_W'(WR_TIMEOUT) : '1;
    localparam bit              TO_EN   = (WR_TIMEOUT != 0);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_owner_q, rsp_owner_d;

    logic [1:0]  req_v;
    logic        pick_valid;
    logic        pick;
    logic        sel;
    logic        sel_we;
    logic        sel_sext;
    logic [1:0]  sel_acc;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  gnt_v;
    logic [1:0]  err_v;
    logic [1:0]  rvalid_v;
    logic [31:0] cnt_ext;
    logic        timeout_hit;

    assign req_v = {m1_req_i, m0_req_i};

    rr_pick2 u_pick (
        .req_i   (req_v),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .pick_o  (pick)
    );

    // While locked, the owner's payload drives the port regardless of requests.
    assign sel = (state_q == ARB_WR_WAIT) ? owner_q : pick;

    // Payload mux for the master currently driving the memory port.
    always_comb begin
        if (sel) begin
            sel_we    = m1_we_i;
            sel_sext  = m1_sext_i;
            sel_acc   = m1_acc_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end else begin
            sel_we    = m0_we_i;
            sel_sext  = m0_sext_i;
            sel_acc   = m0_acc_i;
            sel_addr  = m0_addr_i;
            sel_wdata = m0_wdata_i;
        end
    end

    // cnt_q counts WR_WAIT cycles; the issuing IDLE cycle is the extra +1.
    assign cnt_ext     = 32'(cnt_q);
    assign timeout_hit = TO_EN && ((cnt_ext + 32'd1) >= 32'(WR_TIMEOUT));

    // Next-state, grants and memory-port drive; outputs held at 0 in reset.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_owner_d  = rsp_owner_q;
        gnt_v        = 2'b00;
        err_v        = 2'b00;
        mem_r_en_o   = 1'b0;
        mem_sext_o   = 1'b0;
        mem_acc_r_o  = 2'b00;
        mem_addr_r_o = 32'h0;
        mem_wr_en_o  = 1'b0;
        mem_acc_w_o  = 2'b00;
        mem_addr_w_o = 32'h0;
        mem_data_w_o = 32'h0;
        if (rstn_i) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        last_d = pick;
                        if (!sel_we) begin
                            mem_r_en_o   = 1'b1;
                            mem_sext_o   = sel_sext;
                            mem_acc_r_o  = sel_acc;
                            mem_addr_r_o = sel_addr;
                            gnt_v[pick]  = 1'b1;
                            rsp_valid_d  = 1'b1;
                            rsp_owner_d  = pick;
                        end else begin
                            mem_wr_en_o  = 1'b1;
                            mem_acc_w_o  = sel_acc;
                            mem_addr_w_o = sel_addr;
                            mem_data_w_o = sel_wdata;
                            if (mem_wr_ready_i) begin
                                gnt_v[pick] = 1'b1;
                            end else begin
                                state_d = ARB_WR_WAIT;
                                owner_d = pick;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                ARB_WR_WAIT: begin
                    if (timeout_hit) begin
                        gnt_v[owner_q] = 1'b1;
                        err_v[owner_q] = 1'b1;
                        state_d        = ARB_IDLE;
                    end else begin
                        mem_wr_en_o  = 1'b1;
                        mem_acc_w_o  = sel_acc;
                        mem_addr_w_o = sel_addr;
                        mem_data_w_o = sel_wdata;
                        if (mem_wr_ready_i) begin
                            gnt_v[owner_q] = 1'b1;
                            state_d        = ARB_IDLE;
                        end else if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // Read response routing: data arrives the cycle after mem_r_en_o.
    always_comb begin
        rvalid_v   = 2'b00;
        m0_rdata_o = 32'h0;
        m1_rdata_o = 32'h0;
        if (rsp_valid_q) begin
            rvalid_v[rsp_owner_q] = 1'b1;
            if (rsp_owner_q) begin
                m1_rdata_o = mem_data_r_i;
            end else begin
                m0_rdata_o = mem_data_r_i;
            end
        end
    end

    assign m0_gnt_o    = gnt_v[0];
    assign m1_gnt_o    = gnt_v[1];
    assign m0_err_o    = err_v[0];
    assign m1_err_o    = err_v[1];
    assign m0_rvalid_o = rvalid_v[0];
    assign m1_rvalid_o = rvalid_v[1];

    // State, lock owner, fairness pointer, timeout counter and response tag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_M_CPU;
            last_q      <= ARB_M_LOADER;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= ARB_M_CPU;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

endmodule
